gate_seq1: RTL and testbench
============================

Name: gate_seq1

Overview:
- Frame-rate sequencer for the level-1 barrier block between the two players' paths.
- Turns the raw `button_pressed` pair into a sequenced barrier:
  - animated height,
  - hold-open timer,
  - occupancy safety,
  - a single `gate_open` qualifier consumed by the player movement controllers.
- Also detects level completion: both players parked at the exit for a run of frames.
- Sits between the button/input logic and the per-player control and draw blocks.

Parameters:
- GATE_X_MIN, 310, left x edge of barrier region (inclusive)
- GATE_X_MAX, 450, right x edge of barrier region (inclusive)
- GATE_H, 120, closed barrier height in pixels (≤255)
- STEP, 4, pixels moved per frame while opening or closing
- HOLD_FRAMES, 60, frames the gate stays open after release
- EXIT_X, 640, x at or beyond which a player counts as at the exit
- EXIT_FRAMES, 30, consecutive frames both players must be at the exit

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- v_tick  in  1  vertical sync tick; may stay high for many clk cycles
- button_pressed  in  2  per-player button; any nonzero value = pressed
- xpos_player1  in  12  player 1 x position
- xpos_player2  in  12  player 2 x position
- gate_open  out  1  barrier passable; 1 only in OPEN or HOLD
- gate_height  out  8  current barrier height in pixels; 0 = fully open
- gate_state  out  GateState  current FSM state, for drawing and debug
- level_done  out  1  sticky level-complete flag

Behaviour:
- Frame tick:
  - f_tick = v_tick & ~v_tick_q, where v_tick_q is registered.
  - All state, counter and flag updates happen only on clk edges where f_tick=1.
  - A v_tick held high for N cycles yields exactly one f_tick.
- occupied = either player's x in [GATE_X_MIN, GATE_X_MAX]. Comparisons are unsigned, 12-bit.
- pressed = |button_pressed.
- Reset values (asynchronous, take effect immediately without a clk edge):
  - state CLOSED, gate_height GATE_H, hold_cnt 0, exit_cnt 0, level_done 0, v_tick_q 0.
- FSM transitions, evaluated on f_tick:
  - CLOSED: pressed → OPENING. Height is unchanged on the transition tick.
  - OPENING:
    - !pressed & !occupied → CLOSING.
    - Otherwise height = max(height−STEP, 0); when the new height is 0 → OPEN, on the same tick.
  - OPEN: !pressed → HOLD, with hold_cnt loaded to HOLD_FRAMES−1.
  - HOLD:
    - pressed → OPEN.
    - Else hold_cnt==0 & !occupied → CLOSING.
    - Else hold_cnt decrements, saturating at 0.
    - If hold_cnt==0 while occupied, stay in HOLD until the region is clear.
  - CLOSING:
    - pressed | occupied → OPENING. Height is unchanged on this tick.
    - Else height = min(height+STEP, GATE_H); when the new height is GATE_H → CLOSED.
- Simultaneous events: pressed takes priority over timer expiry and over occupancy checks.
- Arithmetic widths:
  - Height arithmetic is 9-bit internally before saturation; gate_height is never outside [0, GATE_H].
  - hold_cnt and exit_cnt are 8 bits wide.
- gate_open and gate_state are decoded directly from the state register: no added latency, no glitches.
- Level completion:
  - On each f_tick, if both x ≥ EXIT_X, exit_cnt increments, saturating; otherwise exit_cnt clears.
  - When exit_cnt reaches EXIT_FRAMES, level_done sets and stays set until rst.
  - The gate FSM keeps running after level_done.

Optional Feature:
- Macro: GATE_SEQ1_AUTOCLOSE_EN.
- Defined: behaviour exactly as above (HOLD timer, automatic close).
- Undefined:
  - OPEN is terminal: release does not leave OPEN, and HOLD is unreachable.
  - The hold_cnt logic is removed.
  - OPENING and CLOSING behave as above; only a fully opened gate latches open.

Decomposition:
- state_pkg gains typedef enum GateState {G_CLOSED, G_OPENING, G_OPEN, G_HOLD, G_CLOSING}.
- Default geometry constants belong in state_pkg: GATE_X_MIN, GATE_X_MAX, GATE_H.
  - The player controllers share these constants.
- One sub-module: tick_edge (v_tick rising-edge detector with async reset), reusable by the player controllers.

Test Plan:
- Open sequence:
  - Stimulus: defaults, button_pressed=2'b01 held, one f_tick per frame.
  - Response: tick 1 → OPENING with height 120; height falls 4 per tick; tick 31 → OPEN, gate_height=0, gate_open=1.
- Hold and close:
  - Stimulus: from OPEN, release.
  - Response: OPEN→HOLD on next tick; CLOSING 60 ticks later; height rises 4 per tick; CLOSED with height 120 after 30 more ticks; gate_open=0 from CLOSING onward.
- Occupancy safety:
  - Stimulus: in HOLD with xpos_player1=400 when hold_cnt hits 0.
  - Response: stays HOLD, gate_open=1. After setting xpos_player1=500, next tick → CLOSING.
  - Stimulus: occupied during CLOSING.
  - Response: → OPENING.
- Tick qualification:
  - Stimulus: v_tick high for 50 cycles.
  - Response: exactly one height step.
  - Stimulus: v_tick toggling with button released while CLOSED.
  - Response: no change.
- Level done:
  - Stimulus: x1=x2=650 for 30 ticks.
  - Response: level_done=1 and stays 1 after x drops.
  - Stimulus: x2=600 at tick 20.
  - Response: count restarts, no flag at tick 30.
- Async reset:
  - Stimulus: rst mid-OPENING with height 60, clk stopped.
  - Response: gate_height=120, gate_state=G_CLOSED, level_done=0 immediately.
  - Build variant: with the macro undefined, release in OPEN keeps gate_open=1 indefinitely.

Source files
------------

// File: rtl/gate_seq1_pkg.sv
// Shared types and default barrier geometry for the level-1 gate and the
// player controllers that need to agree on where the barrier is.
package state_pkg;

  localparam int unsigned GATE_X_MIN = 310;
  localparam int unsigned GATE_X_MAX = 450;
  localparam int unsigned GATE_H     = 120;

  typedef enum logic [2:0] {
    G_CLOSED,
    G_OPENING,
    G_OPEN,
    G_HOLD,
    G_CLOSING
  } GateState;

  // Inclusive unsigned span test on 12-bit screen coordinates.
  function automatic logic in_span(input logic [11:0] x,
                                   input logic [11:0] lo,
                                   input logic [11:0] hi);
    return (x >= lo) && (x <= hi);
  endfunction

endpackage

// File: rtl/gate_seq1_tick_edge.sv
// Rising-edge detector for the vertical sync level: one pulse per frame no
// matter how long v_tick stays high.
module tick_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic level_i,
  output logic pulse_o
);

  logic level_q;

  // Remember last cycle's level so only the low-to-high transition pulses.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) level_q <= 1'b0;
    else       level_q <= level_i;
  end

  assign pulse_o = level_i & ~level_q;

endmodule

// File: rtl/gate_seq1.sv
// Frame-rate sequencer for the level-1 barrier: animated height, occupancy
// safety, gate_open qualifier and level-completion detection.
// Build option GATE_SEQ1_AUTOCLOSE_EN: when defined, a released open gate
// enters HOLD and closes automatically after HOLD_FRAMES; when undefined,
// OPEN is terminal and the hold timer does not exist.
module gate_seq1 import state_pkg::*; #(
  parameter int unsigned GATE_X_MIN  = state_pkg::GATE_X_MIN,
  parameter int unsigned GATE_X_MAX  = state_pkg::GATE_X_MAX,
  parameter int unsigned GATE_H      = state_pkg::GATE_H,
  parameter int unsigned STEP        = 4,
  parameter int unsigned EXIT_X      = 640,
  parameter int unsigned EXIT_FRAMES = 30
`ifdef GATE_SEQ1_AUTOCLOSE_EN
  , parameter int unsigned HOLD_FRAMES = 60
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        v_tick,
  input  logic [1:0]  button_pressed,
  input  logic [11:0] xpos_player1,
  input  logic [11:0] xpos_player2,
  output logic        gate_open,
  output logic [7:0]  gate_height,
  output GateState    gate_state,
  output logic        level_done
);

  localparam logic [11:0] XMIN12 = 12'(GATE_X_MIN);
  localparam logic [11:0] XMAX12 = 12'(GATE_X_MAX);
  localparam logic [11:0] EXIT12 = 12'(EXIT_X);
  localparam logic [8:0]  H9     = 9'(GATE_H);
  localparam logic [7:0]  H8     = 8'(GATE_H);
  localparam logic [8:0]  STEP9  = 9'(STEP);
  localparam logic [7:0]  EXIT8  = 8'(EXIT_FRAMES);
`ifdef GATE_SEQ1_AUTOCLOSE_EN
  localparam logic [7:0]  HOLD8  = 8'(HOLD_FRAMES - 1);
`endif

  logic       f_tick;
  logic       pressed;
  logic       occupied;
  logic       both_exit;

  GateState   state_q;
  logic [7:0] height_q;
`ifdef GATE_SEQ1_AUTOCLOSE_EN
  logic [7:0] hold_cnt_q;
`endif
  logic [7:0] exit_cnt_q, exit_cnt_d;
  logic       level_done_q;

  logic [8:0] dn9, up9;
  logic [7:0] height_dn, height_up;

  tick_edge u_tick_edge (
    .clk_i   (clk),
    .rst_i   (rst),
    .level_i (v_tick),
    .pulse_o (f_tick)
  );

  assign pressed   = |button_pressed;
  assign occupied  = in_span(xpos_player1, XMIN12, XMAX12) |
                     in_span(xpos_player2, XMIN12, XMAX12);
  assign both_exit = (xpos_player1 >= EXIT12) && (xpos_player2 >= EXIT12);

  // Saturating one-step height moves; 9-bit so the borrow/overflow is visible.
  always_comb begin
    dn9       = {1'b0, height_q} - STEP9;
    up9       = {1'b0, height_q} + STEP9;
    height_dn = dn9[8] ? '0 : dn9[7:0];
    height_up = (up9 >= H9) ? H8 : up9[7:0];
  end

  // Gate FSM with height animation and hold timer, advanced once per frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= G_CLOSED;
      height_q   <= H8;
`ifdef GATE_SEQ1_AUTOCLOSE_EN
      hold_cnt_q <= '0;
`endif
    end else if (f_tick) begin
      unique case (state_q)
        G_CLOSED: begin
          if (pressed) state_q <= G_OPENING;
        end
        G_OPENING: begin
          if (!pressed && !occupied) begin
            state_q <= G_CLOSING;
          end else begin
            height_q <= height_dn;
            if (height_dn == '0) state_q <= G_OPEN;
          end
        end
        G_OPEN: begin
`ifdef GATE_SEQ1_AUTOCLOSE_EN
          if (!pressed) begin
            state_q    <= G_HOLD;
            hold_cnt_q <= HOLD8;
          end
`else
          state_q <= G_OPEN;
`endif
        end
        G_HOLD: begin
`ifdef GATE_SEQ1_AUTOCLOSE_EN
          // Press wins over expiry; an occupied region parks us at zero.
          if (pressed) begin
            state_q <= G_OPEN;
          end else if (hold_cnt_q == '0 && !occupied) begin
            state_q <= G_CLOSING;
          end else if (hold_cnt_q != '0) begin
            hold_cnt_q <= hold_cnt_q - 8'd1;
          end
`else
          state_q <= G_OPEN;
`endif
        end
        G_CLOSING: begin
          if (pressed || occupied) begin
            state_q <= G_OPENING;
          end else begin
            height_q <= height_up;
            if (height_up == H8) state_q <= G_CLOSED;
          end
        end
        default: state_q <= G_CLOSED;
      endcase
    end
  end

  // Next exit-run count: saturating while both players sit at the exit.
  always_comb begin
    exit_cnt_d = '0;
    if (both_exit) exit_cnt_d = (exit_cnt_q == '1) ? exit_cnt_q : exit_cnt_q + 8'd1;
  end

  // Exit run counter and sticky level-complete flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exit_cnt_q   <= '0;
      level_done_q <= 1'b0;
    end else if (f_tick) begin
      exit_cnt_q <= exit_cnt_d;
      if (exit_cnt_d >= EXIT8) level_done_q <= 1'b1;
    end
  end

  assign gate_open   = (state_q == G_OPEN) || (state_q == G_HOLD);
  assign gate_height = height_q;
  assign gate_state  = state_q;
  assign level_done  = level_done_q;

endmodule

// File: tb/tb_gate_seq1.sv
// Self-checking bench for gate_seq1: directed vector table, hand-written
// multi-cycle sequences and randomized frames against a frame-level model.
module tb_gate_seq1;
  import state_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        v_tick;
  logic [1:0]  btn;
  logic [11:0] x1, x2;
  logic        gate_open;
  logic [7:0]  gate_height;
  GateState    gate_state;
  logic        level_done;
  bit          clk_en = 1'b1;

  int tests = 0;
  int fails = 0;

  gate_seq1 dut (
    .clk            (clk),
    .rst            (rst),
    .v_tick         (v_tick),
    .button_pressed (btn),
    .xpos_player1   (x1),
    .xpos_player2   (x2),
    .gate_open      (gate_open),
    .gate_height    (gate_height),
    .gate_state     (gate_state),
    .level_done     (level_done)
  );

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  // ---------------- reference model (one call per frame) ----------------
  localparam int M_XMIN = 310, M_XMAX = 450, M_H = 120, M_STEP = 4;
  localparam int M_HOLD = 60, M_EXIT_X = 640, M_EXIT_N = 30;

  GateState m_st;
  int       m_h, m_hold, m_exit;
  bit       m_done;

  function automatic bit in_gate(input int x);
    return (x >= M_XMIN) && (x <= M_XMAX);
  endfunction

  task automatic model_reset();
    m_st = G_CLOSED; m_h = M_H; m_hold = 0; m_exit = 0; m_done = 0;
  endtask

  task automatic model_frame();
    bit pr, occ;
    pr  = (btn != 2'b00);
    occ = in_gate(int'(x1)) || in_gate(int'(x2));
    case (m_st)
      G_CLOSED:  if (pr) m_st = G_OPENING;
      G_OPENING: begin
        if (!pr && !occ) m_st = G_CLOSING;
        else begin
          m_h = (m_h > M_STEP) ? m_h - M_STEP : 0;
          if (m_h == 0) m_st = G_OPEN;
        end
      end
      G_OPEN: begin
`ifdef GATE_SEQ1_AUTOCLOSE_EN
        if (!pr) begin m_st = G_HOLD; m_hold = M_HOLD - 1; end
`endif
      end
      G_HOLD: begin
        if (pr) m_st = G_OPEN;
        else if (m_hold == 0 && !occ) m_st = G_CLOSING;
        else if (m_hold > 0) m_hold--;
      end
      G_CLOSING: begin
        if (pr || occ) m_st = G_OPENING;
        else begin
          m_h = (m_h + M_STEP > M_H) ? M_H : m_h + M_STEP;
          if (m_h == M_H) m_st = G_CLOSED;
        end
      end
      default: ;
    endcase
    if (int'(x1) >= M_EXIT_X && int'(x2) >= M_EXIT_X) begin
      if (m_exit < 255) m_exit++;
    end else m_exit = 0;
    if (m_exit >= M_EXIT_N) m_done = 1;
  endtask

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cmp_model(input string tag);
    bit m_open;
    m_open = (m_st == G_OPEN) || (m_st == G_HOLD);
    check({tag, ".state"},  32'(gate_state),  32'(m_st));
    check({tag, ".height"}, 32'(gate_height), 32'(m_h));
    check({tag, ".open"},   32'(gate_open),   32'(m_open));
    check({tag, ".done"},   32'(level_done),  32'(m_done));
  endtask

  task automatic do_reset();
    rst = 1'b1; v_tick = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // One frame: v_tick high for hi cycles, low for lo cycles; model steps once.
  task automatic frame(input int hi, input int lo);
    @(negedge clk) v_tick = 1'b1;
    repeat (hi) @(negedge clk);
    v_tick = 1'b0;
    model_frame();
    repeat (lo) @(negedge clk);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [1:0]  b;
    logic [11:0] xa, xb;
    int          n;
    GateState    st;
    int          h;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [1:0] b, input int xa, input int xb, input int n,
                     input GateState st, input int h);
    vec_t v;
    v.b = b; v.xa = 12'(xa); v.xb = 12'(xb); v.n = n; v.st = st; v.h = h;
    tbl.push_back(v);
  endtask

  logic [11:0] xsel [10] = '{12'd0, 12'd309, 12'd310, 12'd400, 12'd450,
                             12'd451, 12'd639, 12'd640, 12'd650, 12'd4095};

  initial begin
    bit press_mode;
    rst = 1'b1; v_tick = 1'b0; btn = '0; x1 = '0; x2 = '0;
    model_reset();
    #1;
    check("rst.state",  32'(gate_state),  32'(G_CLOSED));
    check("rst.height", 32'(gate_height), 32'd120);
    check("rst.open",   32'(gate_open),   32'd0);
    check("rst.done",   32'(level_done),  32'd0);
    do_reset();

    add(2'b00,   0,   0,  3, G_CLOSED,  120);
    add(2'b01,   0,   0,  1, G_OPENING, 120);
    add(2'b10,   0,   0, 10, G_OPENING,  80);
    add(2'b00,   0,   0,  1, G_CLOSING,  80);
    add(2'b00,   0,   0,  3, G_CLOSING,  92);
    add(2'b00,   0, 400,  1, G_OPENING,  92);
    add(2'b00,   0,   0,  1, G_CLOSING,  92);
    add(2'b00, 309, 451,  7, G_CLOSED,  120);
    add(2'b00, 400,   0,  3, G_CLOSED,  120);
    add(2'b01, 400,   0,  1, G_OPENING, 120);
    add(2'b00,   0, 310, 30, G_OPEN,      0);
`ifdef GATE_SEQ1_AUTOCLOSE_EN
    add(2'b00,   0,   0,  5, G_HOLD,      0);
    add(2'b11,   0,   0,  1, G_OPEN,      0);
    add(2'b00,   0,   0,  1, G_HOLD,      0);
    add(2'b00, 400,   0, 65, G_HOLD,      0);
    add(2'b00, 500,   0,  1, G_CLOSING,   0);
    add(2'b00, 500,   0,  1, G_CLOSING,   4);
    add(2'b00, 450,   0,  1, G_OPENING,   4);
    add(2'b00, 451,   0,  1, G_CLOSING,   4);
    add(2'b00,   0,   0, 29, G_CLOSED,  120);
`else
    add(2'b00,   0,   0, 100, G_OPEN,     0);
    add(2'b11,   0,   0,  5, G_OPEN,      0);
    add(2'b00, 309,   0,  5, G_OPEN,      0);
`endif

    for (int i = 0; i < tbl.size(); i++) begin
      btn = tbl[i].b; x1 = tbl[i].xa; x2 = tbl[i].xb;
      repeat (tbl[i].n) begin
        frame(1, 1);
        cmp_model("tbl.mdl");
      end
      check($sformatf("tbl%0d.state", i),  32'(gate_state),  32'(tbl[i].st));
      check($sformatf("tbl%0d.height", i), 32'(gate_height), 32'(tbl[i].h));
      check($sformatf("tbl%0d.open", i),   32'(gate_open),
            32'((tbl[i].st == G_OPEN) || (tbl[i].st == G_HOLD)));
    end

    // Long v_tick high: exactly one step.
    do_reset();
    btn = 2'b01; x1 = '0; x2 = '0;
    frame(1, 1);
    frame(50, 2);
    check("vhold.height", 32'(gate_height), 32'd116);
    check("vhold.state",  32'(gate_state),  32'(G_OPENING));

    // Toggling v_tick while closed and released: nothing moves.
    do_reset();
    btn = 2'b00; x1 = 12'd400;
    repeat (10) frame(1, 1);
    check("idle.state",  32'(gate_state),  32'(G_CLOSED));
    check("idle.height", 32'(gate_height), 32'd120);

    // Interrupted exit run: restart, no flag at tick 30, flag at tick 50.
    do_reset();
    x1 = 12'd650; x2 = 12'd640;
    repeat (19) frame(1, 1);
    x2 = 12'd600; frame(1, 1);
    x2 = 12'd640;
    repeat (10) frame(1, 1);
    check("exit_restart.t30", 32'(level_done), 32'd0);
    repeat (19) frame(1, 1);
    check("exit_restart.t49", 32'(level_done), 32'd0);
    frame(1, 1);
    check("exit_restart.t50", 32'(level_done), 32'd1);

    // Clean exit run of exactly 30 frames, then flag stays after leaving.
    do_reset();
    x1 = 12'd650; x2 = 12'd650;
    repeat (29) frame(1, 1);
    check("exit.t29", 32'(level_done), 32'd0);
    frame(1, 1);
    check("exit.t30", 32'(level_done), 32'd1);
    cmp_model("exit.mdl");
    x1 = 12'd0;
    repeat (5) frame(1, 1);
    check("exit.sticky", 32'(level_done), 32'd1);

    // Randomized frames against the model.
    press_mode = 1'b0;
    for (int f = 0; f < 600; f++) begin
      if (f % 150 == 0) do_reset();
      if ($urandom_range(0, 15) == 0) press_mode = ~press_mode;
      btn = press_mode ? 2'($urandom_range(1, 3)) : 2'b00;
      if ($urandom_range(0, 7) == 0) x1 = xsel[$urandom_range(0, 9)];
      if ($urandom_range(0, 7) == 0) x2 = xsel[$urandom_range(0, 9)];
      frame(int'($urandom_range(1, 4)), int'($urandom_range(1, 3)));
      cmp_model("rnd");
    end

    // Async reset mid-OPENING with the clock stopped (level_done set first).
    do_reset();
    x1 = 12'd650; x2 = 12'd650; btn = 2'b00;
    repeat (30) frame(1, 1);
    check("ar.pre_done", 32'(level_done), 32'd1);
    x1 = '0; x2 = '0; btn = 2'b01;
    repeat (16) frame(1, 1);
    check("ar.pre_height", 32'(gate_height), 32'd60);
    check("ar.pre_state",  32'(gate_state),  32'(G_OPENING));
    clk_en = 1'b0;
    #20;
    rst = 1'b1;
    #1;
    check("ar.height", 32'(gate_height), 32'd120);
    check("ar.state",  32'(gate_state),  32'(G_CLOSED));
    check("ar.done",   32'(level_done),  32'd0);
    check("ar.open",   32'(gate_open),   32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
